// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

    // Value the buffer slots take on reset: pc 0, a NOP, no fault.
    localparam fetch_entry_t RESET_ENTRY = '{pc: '0, instr: NOP_INSTR, fault: 1'b0};

    function automatic fetch_entry_t make_entry(
        input logic [FETCH_XLEN-1:0] pc,
        input logic [FETCH_XLEN-1:0] instr,
        input logic                  fault
    );
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; head is read straight from a slot register.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    fetch_entry_t     slots_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full buffer is allowed when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = slots_q[rd_ptr_q];

    // Pointer and occupancy next-state; clear empties the buffer regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset gives the head a defined NOP value before the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) slots_q[i] <= RESET_ENTRY;
        end else if (do_push && !clear_i) begin
            slots_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, halt-on-fault flag, loadable instruction memory and fetch buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                XLEN       = 32,
    parameter int                IMEM_DEPTH = 64,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0]   RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_instr,
    output logic                          out_fault
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    // Program memory starts out full of NOPs and survives reset.
    logic [XLEN-1:0] imem_q [IMEM_DEPTH] = '{default: NOP_INSTR};

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             halted_q, halted_d;
    logic [IDX_W-1:0] fetch_idx;
    logic             misaligned;
    logic             pop;
    logic             issue;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign fetch_idx  = pc_q[IDX_W+1:2];
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign issue      = ~halted_q & ~redirect_valid & (~fifo_full | pop);

    // Asynchronous read: a same-cycle write lands at the edge, so the fetch sees the old word.
    assign push_entry = misaligned ? make_entry(pc_q, NOP_INSTR, 1'b1)
                                   : make_entry(pc_q, imem_q[fetch_idx], 1'b0);

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_fault = head.fault;

    // PC and halt next-state: redirect wins, a misaligned issue halts with the PC held.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else if (issue) begin
            if (misaligned) halted_d = 1'b1;
            else            pc_d     = pc_q + XLEN'(4);
        end
    end

    // PC and halt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // Program-load port; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (imem_we && !reset) imem_q[imem_waddr] <= imem_wdata;
    end

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (redirect_valid),
        .push_i     (issue),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int IMEM_DEPTH = 64;
    localparam int FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32), .IMEM_DEPTH(IMEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_fault(out_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [IMEM_DEPTH];
    logic [31:0] m_pc;
    bit          m_halted;
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          deadbeef_seen = 0;
    bit          mon_en = 1'b0;

    // Reference model: fetch buffer as a bounded queue, evaluated at every rising edge.
    initial begin
        exp_t e;
        int   idx;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                m_pc     = RESET_PC;
                m_halted = 1'b0;
            end else begin
                if (exp_q.size() > 0 && out_ready) begin
                    e = exp_q.pop_front();
                    delivered++;
                    if (e.instr == 32'hDEADBEEF) deadbeef_seen++;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    m_pc     = redirect_pc;
                    m_halted = 1'b0;
                end else if (!m_halted && exp_q.size() < FIFO_DEPTH) begin
                    if (m_pc % 4 != 0) begin
                        exp_q.push_back('{m_pc, NOP_INSTR, 1'b1});
                        m_halted = 1'b1;
                    end else begin
                        idx = int'((m_pc / 4) % IMEM_DEPTH);
                        exp_q.push_back('{m_pc, m_mem[idx], 1'b0});
                        m_pc = m_pc + 32'd4;
                    end
                end
                if (imem_we) m_mem[imem_waddr] = imem_wdata;
            end
        end
    end

    // Monitor: compare the DUT head against the model head every falling edge.
    initial begin
        logic exp_valid;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_valid = (exp_q.size() > 0);
                checks++;
                if (out_valid !== exp_valid) begin
                    errors++;
                    $display("FAIL valid t=%0t got %b expected %b", $time, out_valid, exp_valid);
                end else if (exp_valid) begin
                    checks++;
                    if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr ||
                        out_fault !== exp_q[0].fault) begin
                        errors++;
                        $display("FAIL head t=%0t got pc=%h instr=%h fault=%b expected pc=%h instr=%h fault=%b",
                                 $time, out_pc, out_instr, out_fault,
                                 exp_q[0].pc, exp_q[0].instr, exp_q[0].fault);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset across one edge and check the reset-state outputs.
    task automatic do_reset();
        reset = 1'b1;
        step(1);
        checks++;
        if (out_valid !== 1'b0 || out_fault !== 1'b0 || out_pc !== 32'h0 || out_instr !== NOP_INSTR) begin
            errors++;
            $display("FAIL reset_state got valid=%b pc=%h instr=%h fault=%b expected 0/00000000/%h/0",
                     out_valid, out_pc, out_instr, out_fault, NOP_INSTR);
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_we        = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step(1);
        redirect_valid = 1'b0;
    endtask

    logic [31:0] prog [5];
    int          delivered_before;

    initial begin
        prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093; prog[2] = 32'h0020_0113;
        prog[3] = 32'h0030_8193; prog[4] = 32'h0041_0213;
        for (int i = 0; i < IMEM_DEPTH; i++) m_mem[i] = NOP_INSTR;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; out_ready = 1'b0;
        step(2);
        mon_en = 1'b1;

        // Load program: words 0..4 fixed, the rest random.
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 6'(i);
            imem_wdata = (i < 5) ? prog[i] : $urandom;
            step(1);
        end
        imem_we = 1'b0;

        // Sequential stream.
        do_reset();
        out_ready = 1'b1;
        step(8);

        // Back-pressure then resume.
        out_ready = 1'b0;
        do_reset();
        step(5);
        out_ready = 1'b1;
        step(6);

        // Redirect to 0x20 while buffer holds pcs 4 and 8.
        out_ready = 1'b0;
        do_reset();
        step(2);
        out_ready = 1'b1;
        step(1);
        redirect(32'h20);
        step(6);

        // Misaligned redirect halts fetch, aligned redirect resumes.
        redirect(32'h22);
        step(6);
        redirect(32'h0);
        step(6);

        // Wrap around the end of memory.
        redirect(32'hFC);
        step(4);

        // Same-cycle write and fetch of word 1.
        do_reset();
        out_ready = 1'b1;
        step(1);
        imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'hDEADBEEF;
        step(1);
        imem_we = 1'b0;
        step(3);
        redirect(32'h4);
        step(4);
        checks++;
        if (deadbeef_seen != 1) begin
            errors++;
            $display("FAIL deadbeef_delivered got %0d expected 1", deadbeef_seen);
        end

        // Reset dominates a simultaneous redirect with a full buffer.
        out_ready = 1'b0;
        step(3);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        do_reset();
        out_ready = 1'b1;
        step(6);

        // Random phase.
        delivered_before = delivered;
        for (int c = 0; c < 800; c++) begin
            out_ready      = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            case ($urandom % 3)
                0:       redirect_pc = $urandom & 32'h0000_01FC;
                1:       redirect_pc = $urandom;
                default: redirect_pc = 32'h0000_0022;
            endcase
            imem_we    = ($urandom % 6) == 0;
            imem_waddr = 6'($urandom);
            imem_wdata = $urandom;
            reset      = ($urandom % 97) == 0;
            step(1);
        end
        reset = 1'b0; redirect_valid = 1'b0; imem_we = 1'b0;
        step(2);
        checks++;
        if (delivered - delivered_before < 100) begin
            errors++;
            $display("FAIL random_throughput got %0d deliveries expected at least 100",
                     delivered - delivered_before);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
